alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 162 ++++++++++++++++
 tb/tb_alu_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined WIDTH-bit ALU with valid/ready on both sides.
// Stage 1 computes the result; stages 2..STAGES are delay registers.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_valid/in_ready input handshake; a, b, op, tag_in payload
//   out_valid/out_ready output handshake
//   result, carry, overflow, zero, illegal, tag_out  presented result
//
// Optional feature: define ALU_SAT_EN to build signed saturating
// add/sub on ops 12/13; otherwise those opcodes report illegal.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             illegal,
    output logic [TAG_W-1:0] tag_out
);

    localparam int M = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } st_t;

    st_t              d [STAGES];
    st_t              nx;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    logic           add_ovf;
    logic           sub_ovf;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign dif     = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[M] == b[M]) & (sum[M] != a[M]);
    assign sub_ovf = (a[M] != b[M]) & (dif[M] != a[M]);

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {M{1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {M{1'b0}}};
`endif

    always_comb begin
        nx     = '0;
        nx.tag = tag_in;
        case (op)
            4'd0: begin
                nx.res   = sum[WIDTH-1:0];
                nx.carry = sum[WIDTH];
                nx.ovf   = add_ovf;
            end
            4'd1: begin
                nx.res   = dif[WIDTH-1:0];
                nx.carry = dif[WIDTH];
                nx.ovf   = sub_ovf;
            end
            4'd2: nx.res = a & b;
            4'd3: nx.res = a | b;
            4'd4: nx.res = a ^ b;
            4'd5: begin
                nx.res   = {a[M-1:0], 1'b0};
                nx.carry = a[M];
            end
            4'd6: begin
                nx.res   = {1'b0, a[M:1]};
                nx.carry = a[0];
            end
            4'd7: begin
                nx.res   = {a[M], a[M:1]};
                nx.carry = a[0];
            end
            4'd8: begin
                nx.res   = {a[M-1:0], a[M]};
                nx.carry = a[M];
            end
            4'd9: begin
                nx.res   = {a[0], a[M:1]};
                nx.carry = a[0];
            end
            4'd10: nx.res = {{M{1'b0}}, $signed(a) < $signed(b)};
            4'd11: nx.res = {{M{1'b0}}, a < b};
`ifdef ALU_SAT_EN
            // on overflow the sign of a gives the clamp direction
            4'd12: begin
                nx.res = add_ovf ? (a[M] ? SMIN : SMAX)
                                 : sum[WIDTH-1:0];
                nx.ovf = add_ovf;
            end
            4'd13: begin
                nx.res = sub_ovf ? (a[M] ? SMIN : SMAX)
                                 : dif[WIDTH-1:0];
                nx.ovf = sub_ovf;
            end
`endif
            default: nx.ill = 1'b1;
        endcase
        nx.zero = (nx.res == '0);
    end

    // A stage may load if it is empty or any stage after it is
    // empty or the consumer takes the head this cycle.
    always_comb begin : ready_chain
        logic r;
        ld = '0;
        r  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = ~v[k] | r;
            r     = ld[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) d[k] <= '0;
        end else begin
            if (ld[0]) begin
                v[0] <= in_valid;
                if (in_valid) d[0] <= nx;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) d[k] <= d[k-1];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[STAGES-1];
    assign result    = d[STAGES-1].res;
    assign carry     = d[STAGES-1].carry;
    assign overflow  = d[STAGES-1].ovf;
    assign zero      = d[STAGES-1].zero;
    assign illegal   = d[STAGES-1].ill;
    assign tag_out   = d[STAGES-1].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against
// an arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;

    localparam int STAGES = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        illegal;
    logic [3:0]  tag_out;

    alu_pipe #(.WIDTH(16), .STAGES(STAGES), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .zero(zero), .illegal(illegal), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        il;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_in  = 0;
    int   n_out = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic exp_t model(int unsigned o, int unsigned x,
                                   int unsigned y, logic [3:0] t);
        exp_t e;
        int   sx, sy, r, s;
        sx = sgn(x);
        sy = sgn(y);
        r  = 0;
        s  = 0;
        e  = '0;
        case (o)
            0: begin
                r   = int'(x + y);
                e.c = (x + y) > 65535;
                e.v = (sx + sy > 32767) || (sx + sy < -32768);
            end
            1: begin
                r   = int'(x) - int'(y);
                e.c = x < y;
                e.v = (sx - sy > 32767) || (sx - sy < -32768);
            end
            2: r = int'(x & y);
            3: r = int'(x | y);
            4: r = int'(x ^ y);
            5: begin r = int'(x * 2); e.c = x >= 32768; end
            6: begin r = int'(x / 2); e.c = (x % 2) == 1; end
            7: begin r = sx >>> 1;    e.c = (x % 2) == 1; end
            8: begin r = int'(x * 2 + x / 32768); e.c = x >= 32768; end
            9: begin r = int'(x / 2 + (x % 2) * 32768); e.c = (x % 2) == 1; end
            10: r = (sx < sy) ? 1 : 0;
            11: r = (x < y) ? 1 : 0;
`ifdef ALU_SAT_EN
            12, 13: begin
                s = (o == 12) ? sx + sy : sx - sy;
                if (s > 32767) begin r = 32767; e.v = 1'b1; end
                else if (s < -32768) begin r = -32768; e.v = 1'b1; end
                else r = s;
            end
`endif
            default: e.il = 1'b1;
        endcase
        e.res = r[15:0];
        e.z   = (e.res == 16'h0000);
        e.tag = t;
        return e;
    endfunction

    // Inputs are already driven; runs from just after a negedge to
    // the next negedge, scoring whatever transfers occur.
    task automatic cycle();
        exp_t e;
        #1;
        check("in_ready", in_ready, (q.size() < STAGES) || out_ready);
        if (q.size() == 0) check("idle_ov", out_valid, 1'b0);
        if (out_valid && q.size() > 0) begin
            e = q[0];
            check("result", result, e.res);
            check("carry", carry, e.c);
            check("overflow", overflow, e.v);
            check("zero", zero, e.z);
            check("illegal", illegal, e.il);
            check("tag", tag_out, e.tag);
            if (out_ready) begin
                void'(q.pop_front());
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(op, a, b, tag_in));
            n_in++;
        end
        @(negedge clk);
    endtask

    task automatic dir(string nm, logic [3:0] o, logic [15:0] x,
                       logic [15:0] y, logic [15:0] er, logic ec,
                       logic ev, logic ez, logic ei);
        int lat;
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        tag_in    = 4'hA;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 8) begin
            cycle();
            lat++;
        end
        check({nm, "_lat"}, lat, STAGES);
        check({nm, "_res"}, result, er);
        check({nm, "_c"}, carry, ec);
        check({nm, "_v"}, overflow, ev);
        check({nm, "_z"}, zero, ez);
        check({nm, "_il"}, illegal, ei);
        check({nm, "_tag"}, tag_out, 4'hA);
        cycle();
    endtask

    logic [15:0] corner [6];

    function automatic logic [15:0] pick();
        if ($urandom % 4 == 0) return corner[$urandom % 6];
        return 16'($urandom);
    endfunction

    initial begin
        int c;
        int sent;
        corner[0] = 16'h0000; corner[1] = 16'h0001;
        corner[2] = 16'h7FFF; corner[3] = 16'h8000;
        corner[4] = 16'hFFFF; corner[5] = 16'h7000;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; op = '0; tag_in = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ov", out_valid, 1'b0);
        check("rst_res", result, 16'h0);
        check("rst_flags", {carry, overflow, zero, illegal}, 4'h0);
        check("rst_tag", tag_out, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ir", in_ready, 1'b1);
        @(negedge clk);

        dir("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 0);
        dir("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0);
        dir("sub_brw", 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0, 0);
        dir("slt", 4'd10, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0, 0);
        dir("sltu", 4'd11, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 1, 0);
        dir("ror", 4'd9, 16'h0001, 16'h0000, 16'h8000, 1, 0, 0, 0);
        dir("ill15", 4'd15, 16'h1234, 16'h0000, 16'h0000, 0, 0, 1, 1);
`ifdef ALU_SAT_EN
        dir("sadd", 4'd12, 16'h7000, 16'h7000, 16'h7FFF, 0, 1, 0, 0);
        dir("ssub", 4'd13, 16'h8000, 16'h0001, 16'h8000, 0, 1, 0, 0);
`else
        dir("ill12", 4'd12, 16'h7000, 16'h7000, 16'h0000, 0, 0, 1, 1);
`endif

        // eight back-to-back ops with the consumer stalled in 3..6
        sent = 0;
        for (c = 0; c < 24; c++) begin
            in_valid  = (sent < 8);
            op        = 4'($urandom % 12);
            a         = pick();
            b         = pick();
            tag_in    = 4'(sent);
            out_ready = !(c >= 3 && c <= 6);
            if (c == 5) begin
                #1;
                check("bp_full_ir", in_ready, 1'b0);
                check("bp_hold_ov", out_valid, 1'b1);
                #1;
            end
            if (in_valid) begin
                #1;
                if (in_ready) sent++;
                #0;
                cycle_pre_sampled();
            end else begin
                cycle();
            end
        end
        check("bp_drained", q.size(), 0);

        // reset with two ops in flight
        in_valid  = 1'b1;
        out_ready = 1'b0;
        op        = 4'd0;
        a         = 16'h0123;
        b         = 16'h0456;
        tag_in    = 4'h5;
        cycle();
        cycle();
        in_valid = 1'b0;
        check("pre_rst_ov", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ov", out_valid, 1'b0);
        check("mid_rst_res", result, 16'h0);
        check("mid_rst_flags", {carry, overflow, zero, illegal}, 4'h0);
        check("mid_rst_tag", tag_out, 4'h0);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) cycle();

        // randomized throttled traffic
        n_in = 0;
        c    = 0;
        while (n_in < 10000 && c < 60000) begin
            in_valid  = ($urandom % 4) != 0;
            op        = 4'($urandom);
            a         = pick();
            b         = pick();
            tag_in    = 4'($urandom);
            out_ready = ($urandom % 3) != 0;
            cycle();
            c++;
        end
        check("rand_count", n_in >= 10000, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (q.size() > 0 && c < 20) begin
            cycle();
            c++;
        end
        check("rand_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    // Same as cycle() but entered 1 time unit after the negedge.
    task automatic cycle_pre_sampled();
        exp_t e;
        check("in_ready", in_ready, (q.size() < STAGES) || out_ready);
        if (q.size() == 0) check("idle_ov", out_valid, 1'b0);
        if (out_valid && q.size() > 0) begin
            e = q[0];
            check("result", result, e.res);
            check("carry", carry, e.c);
            check("overflow", overflow, e.v);
            check("zero", zero, e.z);
            check("illegal", illegal, e.il);
            check("tag", tag_out, e.tag);
            if (out_ready) begin
                void'(q.pop_front());
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(op, a, b, tag_in));
            n_in++;
        end
        @(negedge clk);
    endtask

endmodule
